// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the byte-enabled simple dual-port RAM.
// Imported by the clear controller and the RAM top level.
package sync_ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    function automatic int byte_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear-on-reset sequencer: sweeps every address once after reset, then
// parks in READY until the next reset.
module ram_clear_ctrl
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_done,
    output ram_state_e            state
);

    ram_state_e            r_state;
    ram_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clear writes are suppressed while rst is held so a reset never
    // advances or disturbs the sweep.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        clr_we      = 1'b0;
        case (r_state)
            CLEAR: begin
                clr_we    = ~rst;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == '1) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign clr_addr  = r_cnt;
    assign init_done = (r_state == READY);
    assign state     = r_state;

endmodule

// File: rtl/sync_ram_dp_be.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write policy and a hardware clear after reset.
module sync_ram_dp_be
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_done
);

    localparam int        DEPTH = 2 ** ADDR_WIDTH;
    localparam int        NB    = byte_count(DATA_WIDTH);
    localparam rdw_mode_e MODE  = (RDW_MODE == 1) ? WRITE_FIRST : READ_FIRST;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
        $error("sync_ram_dp_be: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sync_ram_dp_be: RD_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_mode
        $error("sync_ram_dp_be: RDW_MODE must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    ram_state_e            w_state;
    logic                  w_ready;

    ram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr),
        .init_done (init_done),
        .state     (w_state)
    );

    assign w_ready = (w_state == READY) && !rst;

    // Write port: the clear sweep owns the array until READY.
    logic [NB-1:0]         w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    always_comb begin
        w_mem_we    = '0;
        w_mem_addr  = wr_addr;
        w_mem_wdata = wr_data;
        if (w_clr_we) begin
            w_mem_we    = '1;
            w_mem_addr  = w_clr_addr;
            w_mem_wdata = '0;
        end else if (w_ready && wr_en) begin
            w_mem_we = wr_be;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_mem_we[i]) begin
                r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
            end
        end
    end

    // Read port. Handshake: rd_en is a request with no backpressure; each
    // request accepted in READY yields exactly one rd_valid pulse RD_LATENCY
    // edges later, and rd_data holds between pulses.
    logic                  w_rd_fire;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_rd_fire = w_ready && rd_en;
    assign w_collide = w_ready && wr_en && (wr_addr == rd_addr);
    assign w_old     = r_mem[rd_addr];

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                w_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    assign w_rd_word = (MODE == WRITE_FIRST && w_collide) ? w_merged : w_old;

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    if (RD_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_fire;
                if (w_rd_fire) begin
                    r_rd_data <= w_rd_word;
                end
            end
        end
    end else begin : g_lat2
        logic                  r_s1_valid;
        logic [DATA_WIDTH-1:0] r_s1_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1_valid <= 1'b0;
                r_s1_data  <= '0;
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_s1_valid <= w_rd_fire;
                if (w_rd_fire) begin
                    r_s1_data <= w_rd_word;
                end
                r_rd_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rd_data <= r_s1_data;
                end
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule
